uart_tx: RTL and testbench

UART serial transmitter. It is the transmit half of the UART and pairs with the existing receiver on the same baud generator. It serialises a parallel byte into one frame: a start bit, DBIT data bits sent LSB first, an optional parity bit, and stop bit(s). Bit timing uses a shared 16x-oversampling enable, s_tick; the block has no baud counter of its own.

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx - UART serial transmitter.
//
// Serialises one byte per frame: start bit, DBIT data bits (LSB first),
// optional parity bit, then a stop period of SB_TICK oversampling ticks.
// Bit timing comes from a shared 16x-oversampling enable (s_tick). The block
// has no baud counter of its own.
//
// Parameters:
//   DBIT       data bits per frame (5..8)
//   SB_TICK    s_tick count for the stop period (16/24/32 = 1/1.5/2 stop bits)
//   PARITY_EN  1 inserts a parity bit after the last data bit
//   PARITY_ODD parity sense when enabled (0 = even, 1 = odd)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   tx_start     send request, level-sampled, acted on only in IDLE
//   s_tick       one-clk enable pulse at 16x baud
//   din          byte to send (bits above DBIT-1 ignored)
//   tx           registered serial line, idle high
//   tx_busy      high whenever the FSM is not in IDLE
//   tx_done_tick one-clk pulse in the last cycle of the stop period
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic       s_tick,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    localparam logic       P_INIT    = 1'(PARITY_ODD);
    localparam logic       PAR_ON    = (PARITY_EN != 0);

    // Running parity: fold one transmitted data bit into the accumulator.
    function automatic logic parity_acc(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    state_t      state_r;
    logic [4:0]  s_r;
    logic [2:0]  n_r;
    logic [7:0]  b_r;
    logic        p_r;
    logic        tx_r;
    logic        busy_r;

    // Frame sequencer. tx_r is loaded with the level of the *next* bit on the
    // same edge that crosses a bit boundary, so the line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            s_r     <= 5'd0;
            n_r     <= 3'd0;
            b_r     <= 8'd0;
            p_r     <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    // A coincident s_tick is deliberately not counted here.
                    if (tx_start) begin
                        b_r     <= din;
                        s_r     <= 5'd0;
                        p_r     <= P_INIT;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_r == BIT_LAST) begin
                            s_r     <= 5'd0;
                            n_r     <= 3'd0;
                            tx_r    <= b_r[0];
                            state_r <= DATA;
                        end else begin
                            s_r <= s_r + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_r == BIT_LAST) begin
                            s_r <= 5'd0;
                            p_r <= parity_acc(p_r, b_r[0]);
                            b_r <= b_r >> 1;
                            if (n_r == N_LAST) begin
                                if (PAR_ON) begin
                                    tx_r    <= parity_acc(p_r, b_r[0]);
                                    state_r <= PARITY;
                                end else begin
                                    tx_r    <= 1'b1;
                                    state_r <= STOP;
                                end
                            end else begin
                                n_r  <= n_r + 3'd1;
                                // b_r[1] becomes b_r[0] after this shift.
                                tx_r <= b_r[1];
                            end
                        end else begin
                            s_r <= s_r + 5'd1;
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s_r == BIT_LAST) begin
                            s_r     <= 5'd0;
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            s_r <= s_r + 5'd1;
                        end
                    end
                end
                STOP: begin
                    tx_r <= 1'b1;
                    if (s_tick) begin
                        if (s_r == STOP_LAST) begin
                            s_r     <= 5'd0;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            s_r <= s_r + 5'd1;
                        end
                    end
                end
                default: begin
                    s_r     <= 5'd0;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx           = tx_r;
    assign tx_busy      = busy_r;
    assign tx_done_tick = (state_r == STOP) && s_tick && (s_r == STOP_LAST);

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx - directed self-checking bench for uart_tx.
// Four instances cover: defaults (u0), even parity (u1), odd parity (u2),
// DBIT=7 with two stop bits (u3). s_tick pulses every 4 clks, so one bit
// period is 64 clks; line levels are sampled in the middle of each bit.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       s_tick;
    logic [3:0] start_v;
    logic [7:0] din_v [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] done_w;

    int n_vec;
    int n_err;
    int cyc;
    int tcnt;
    int dn_cnt [4];

    uart_tx u0 (.clk(clk), .rst(rst), .tx_start(start_v[0]), .s_tick(s_tick),
                .din(din_v[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rst(rst), .tx_start(start_v[1]),
                .s_tick(s_tick), .din(din_v[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]),
                .tx_done_tick(done_w[1]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .tx_start(start_v[2]),
                .s_tick(s_tick), .din(din_v[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]),
                .tx_done_tick(done_w[2]));
    uart_tx #(.DBIT(7), .SB_TICK(32)) u3 (.clk(clk), .rst(rst), .tx_start(start_v[3]),
                .s_tick(s_tick), .din(din_v[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]),
                .tx_done_tick(done_w[3]));

    // Clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter and s_tick generator (one pulse every 4 clks).
    initial begin
        cyc    = 0;
        tcnt   = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            tcnt   = tcnt + 1;
            s_tick = ((tcnt % 4) == 0);
        end
    end

    // Count done pulses per instance.
    initial begin
        for (int i = 0; i < 4; i++) dn_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (done_w[i]) dn_cnt[i] = dn_cnt[i] + 1;
        end
    end

    // Watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog timeout n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Raise tx_start for one clk on a cycle whose edge also carries s_tick
    // (that tick must not count); t0 is the cycle in which tx_start is high.
    task automatic pulse_start(input int idx, input logic [7:0] d, output int t0);
        @(negedge clk);
        while (!s_tick) @(negedge clk);
        din_v[idx]   = d;
        start_v[idx] = 1'b1;
        t0           = cyc;
        @(negedge clk);
        start_v[idx] = 1'b0;
    endtask

    // Send one frame and check every bit period, the done pulse latency and
    // the return to idle. inj >= 0 fires an ignored tx_start (din=FF) after
    // sampling bit period inj.
    task automatic run_frame(input int idx, input logic [7:0] d, input logic [15:0] expb,
                             input int nb, input int lat, input int inj, input string tag);
        int   t0;
        int   dcyc;
        logic seen;
        pulse_start(idx, d, t0);
        repeat (32) @(negedge clk);
        for (int k = 0; k < nb; k++) begin
            chk($sformatf("%s_bit%0d", tag, k), {31'd0, tx_w[idx]}, {31'd0, expb[k]});
            chk($sformatf("%s_busy%0d", tag, k), {31'd0, busy_w[idx]}, 32'd1);
            if (k == inj) begin
                din_v[idx]   = 8'hFF;
                start_v[idx] = 1'b1;
                @(negedge clk);
                start_v[idx] = 1'b0;
                repeat (63) @(negedge clk);
            end else if (k < nb - 1) begin
                repeat (64) @(negedge clk);
            end
        end
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done_w[idx]) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) chk({tag, "_done_lat"}, dcyc - t0, lat);
        @(negedge clk);
        chk({tag, "_done_1clk"}, {31'd0, done_w[idx]}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy_w[idx]}, 32'd0);
        chk({tag, "_idle_tx"},   {31'd0, tx_w[idx]},   32'd1);
    endtask

    initial begin
        int   bad;
        int   dn0;
        int   t0;
        logic seen;
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start_v = 4'd0;
        for (int i = 0; i < 4; i++) din_v[i] = 8'd0;

        // Reset state.
        repeat (5) @(negedge clk);
        chk("rst_tx",   {28'd0, tx_w},   32'hF);
        chk("rst_busy", {28'd0, busy_w}, 32'h0);
        chk("rst_done", {28'd0, done_w}, 32'h0);
        rst = 1'b0;

        // Idle hold for 1000 clks.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) bad = bad + 1;
        end
        chk("idle_hold", bad, 0);
        chk("idle_no_done", dn_cnt[0] + dn_cnt[1] + dn_cnt[2] + dn_cnt[3], 0);

        // Basic frame, A5: 0 | 1,0,1,0,0,1,0,1 | 1.
        run_frame(0, 8'hA5, 16'h034A, 10, 640, -1, "basic");
        // Parity: A5 has four ones -> even 0, odd 1; 11 bit periods.
        run_frame(1, 8'hA5, 16'h054A, 11, 704, -1, "par_even");
        run_frame(2, 8'hA5, 16'h074A, 11, 704, -1, "par_odd");

        // Busy ignore: 3C with an ignored FF request during data bit 3.
        dn0 = dn_cnt[0];
        run_frame(0, 8'h3C, 16'h0278, 10, 640, 4, "busy_ign");
        repeat (300) @(negedge clk);
        #1;
        chk("busy_ign_one_done", dn_cnt[0] - dn0, 1);
        chk("busy_ign_tx_idle",  {31'd0, tx_w[0]},   32'd1);
        chk("busy_ign_busy",     {31'd0, busy_w[0]}, 32'd0);

        // DBIT=7, 2 stop bits, din=80 -> seven zeros, 128 clks high.
        run_frame(3, 8'h80, 16'h0300, 10, 640, -1, "d7_sb32");

        // Back-to-back with tx_start held high.
        @(negedge clk);
        while (!s_tick) @(negedge clk);
        din_v[0]   = 8'h01;
        start_v[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 800 && !seen; i++) begin
            @(negedge clk);
            if (done_w[0]) seen = 1'b1;
        end
        chk("b2b_done1", {31'd0, seen}, 32'd1);
        @(negedge clk);
        chk("b2b_gap_tx",    {31'd0, tx_w[0]},   32'd1);
        chk("b2b_gap_busy",  {31'd0, busy_w[0]}, 32'd0);
        @(negedge clk);
        chk("b2b_start_tx",   {31'd0, tx_w[0]},   32'd0);
        chk("b2b_start_busy", {31'd0, busy_w[0]}, 32'd1);
        start_v[0] = 1'b0;
        repeat (64) @(negedge clk);
        chk("b2b_f2_bit0", {31'd0, tx_w[0]}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 800 && !seen; i++) begin
            @(negedge clk);
            if (done_w[0]) seen = 1'b1;
        end
        chk("b2b_done2", {31'd0, seen}, 32'd1);
        repeat (10) @(negedge clk);

        // Reset in the middle of data bit 3 of 55.
        pulse_start(0, 8'h55, t0);
        repeat (32 + 64 * 4) @(negedge clk);
        chk("mid_pre_tx", {31'd0, tx_w[0]}, 32'd0);
        #1;
        dn0 = dn_cnt[0];
        rst = 1'b1;
        #1;
        chk("mid_rst_tx",   {31'd0, tx_w[0]},   32'd1);
        chk("mid_rst_busy", {31'd0, busy_w[0]}, 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        #1;
        chk("mid_no_done", dn_cnt[0] - dn0, 0);
        run_frame(0, 8'h55, 16'h02AA, 10, 640, -1, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
